// File: rtl/hdlverifier_capture_ctrl.sv
// Capture sequencer: arm -> pre-trigger fill -> wait for trigger -> post-trigger fill -> done.
// Drives the circular sample buffer write port and records the trigger sample address.
module hdlverifier_capture_ctrl #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_enable,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] pretrig_len,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            state
);

   localparam int CW = ADDR_WIDTH + 1;
   // DEPTH-1: largest pre-trigger window, and DEPTH-1-plen gives the post count
   localparam logic [CW-1:0] DMAX = {1'b0, {ADDR_WIDTH{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PREFILL  = 3'd1,
      S_WAIT     = 3'd2,
      S_POSTFILL = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t          st;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   post;
   logic [CW-1:0]   plen;
   logic [CW-1:0]   plen_in;

   assign plen_in = ({1'b0, pretrig_len} > DMAX) ? DMAX : {1'b0, pretrig_len};
   assign state   = st;
   assign busy    = (st == S_PREFILL) || (st == S_WAIT) || (st == S_POSTFILL);
   assign wr_en   = clk_enable & busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= S_IDLE;
         wr_addr   <= '0;
         trig_addr <= '0;
         done      <= 1'b0;
         cnt       <= '0;
         post      <= '0;
         plen      <= '0;
      end else if (abort) begin
         // addresses are deliberately kept so a partial capture can still be inspected
         st   <= S_IDLE;
         done <= 1'b0;
      end else if (clk_enable) begin
         case (st)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  wr_addr <= '0;
                  done    <= 1'b0;
                  cnt     <= '0;
                  plen    <= plen_in;
                  st      <= (plen_in != '0) ? S_PREFILL : S_WAIT;
               end
            end
            S_PREFILL: begin
               wr_addr <= wr_addr + 1'b1;
               cnt     <= cnt + 1'b1;
               if (cnt + 1'b1 == plen) st <= S_WAIT;
            end
            S_WAIT: begin
               wr_addr <= wr_addr + 1'b1;
               if (trigger) begin
                  trig_addr <= wr_addr;
                  post      <= DMAX - plen;
                  if (plen == DMAX) begin
                     st   <= S_DONE;
                     done <= 1'b1;
                  end else begin
                     st <= S_POSTFILL;
                  end
               end
            end
            S_POSTFILL: begin
               wr_addr <= wr_addr + 1'b1;
               post    <= post - 1'b1;
               if (post == {{(CW-1){1'b0}}, 1'b1}) begin
                  st   <= S_DONE;
                  done <= 1'b1;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Self-checking bench for hdlverifier_capture_ctrl (ADDR_WIDTH=4, DEPTH=16).
// Expected values come from a write-count model of a capture: p pre-trigger writes, trigger on write k.
module tb_hdlverifier_capture_ctrl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          clk_enable = 1'b1;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          trigger = 1'b0;
   logic [AW-1:0] pretrig_len = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] trig_addr;
   logic          busy;
   logic          done;
   logic [2:0]    state;

   int n_pass = 0;
   int n_total = 0;

   hdlverifier_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .arm(arm), .abort(abort),
      .trigger(trigger), .pretrig_len(pretrig_len), .wr_en(wr_en), .wr_addr(wr_addr),
      .trig_addr(trig_addr), .busy(busy), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One clock with the given inputs; returns at posedge+1 with inputs still applied.
   task automatic cyc(input logic ce, input logic a, input logic t, input logic ab);
      clk_enable = ce; arm = a; trigger = t; abort = ab;
      @(posedge clk); #1;
   endtask

   // mode 0: clk_enable always 1, 1: toggles 1,0,1,0, 2: random ~70%.
   // noise: random trigger where the spec says it must be ignored (PREFILL/POSTFILL).
   task automatic run_capture(input int p, input int k, input int mode, input bit noise, input string nm);
      int w, total, c, exp_st;
      logic ce;
      total = k + (DEPTH - 1 - p);
      pretrig_len = AW'(p);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      arm = 1'b0;
      w = 0; c = 0;
      while (w < total && c < 4000) begin
         case (mode)
            0:       ce = 1'b1;
            1:       ce = (c % 2 == 0);
            default: ce = ($urandom_range(99) < 70);
         endcase
         clk_enable = ce;
         if (w >= p && w < k) trigger = (w == k - 1);
         else                 trigger = noise ? 1'($urandom_range(1)) : 1'b0;
         exp_st = (w < p) ? 1 : (w < k) ? 2 : 3;
         @(negedge clk);
         chk({nm, ".wr_en"}, wr_en, ce);
         chk({nm, ".state"}, state, exp_st);
         if (ce) chk({nm, ".wr_addr"}, wr_addr, w % DEPTH);
         @(posedge clk); #1;
         if (ce) w++;
         c++;
      end
      chk({nm, ".finished_in_budget"}, (w == total), 1);
      clk_enable = 1'b1; trigger = 1'b0;
      @(negedge clk);
      chk({nm, ".done_state"}, state, 4);
      chk({nm, ".done"}, done, 1);
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".wr_en_idle"}, wr_en, 0);
      chk({nm, ".trig_addr"}, trig_addr, (k - 1) % DEPTH);
      chk({nm, ".end_addr"}, wr_addr, total % DEPTH);
      // last DEPTH writes start at write index total-DEPTH
      chk({nm, ".oldest"}, (trig_addr - AW'(p)) & 4'hF, (total - DEPTH) % DEPTH);
      @(posedge clk); #1;
   endtask

   initial begin
      int p, k;
      #12 reset = 1'b0;
      // 1: reset state
      @(negedge clk);
      chk("rst.state", state, 0);
      chk("rst.wr_en", wr_en, 0);
      chk("rst.done", done, 0);
      chk("rst.wr_addr", wr_addr, 0);
      chk("rst.trig_addr", trig_addr, 0);
      chk("rst.busy", busy, 0);
      @(posedge clk); #1;

      run_capture(4, 10, 0, 1'b0, "t2");
      run_capture(4, 10, 0, 1'b1, "t3");
      run_capture(0, 1, 0, 1'b0, "t4");
      run_capture(4, 10, 1, 1'b0, "t5");
      run_capture(15, 16, 0, 1'b0, "t6max");

      // 6: arm while busy ignored, abort in POSTFILL (with clk_enable low)
      pretrig_len = AW'(2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6.arm_ignored_addr", wr_addr, 2);
      chk("t6.arm_ignored_state", state, 2);
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t6.trig_addr", trig_addr, 2);
      chk("t6.postfill", state, 3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6.abort_state", state, 0);
      chk("t6.abort_done", done, 0);
      chk("t6.abort_addr_held", wr_addr, 4);
      chk("t6.abort_trig_held", trig_addr, 2);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6.arm_no_ce", state, 0);
      abort = 1'b0; arm = 1'b0;

      // randomized captures, chained from DONE
      for (int i = 0; i < 6; i++) begin
         p = $urandom_range(15);
         k = p + 1 + $urandom_range(20);
         if (p == 15) k = 16;
         run_capture(p, k, 2, 1'b1, $sformatf("rnd%0d", i));
      end

      // asynchronous reset mid-capture
      pretrig_len = AW'(3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("arst.state", state, 0);
      chk("arst.wr_addr", wr_addr, 0);
      chk("arst.trig_addr", trig_addr, 0);
      chk("arst.done", done, 0);
      chk("arst.wr_en", wr_en, 0);
      #10 reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
